button_event: RTL and testbench
===============================

// Module: button_event
// PURPOSE
//   Classifies the debounced push-button level into one-cycle event pulses:
//   press edge, short press, long press and double click. It sits directly
//   downstream of the debouncer, consuming its 'semnal' output, and feeds
//   the control FSMs that need discrete button commands instead of a level.
// PARAMETERS
//   LONG_CYCLES  50_000_000  high samples (incl. rise sample) needed for long press; >=2
//   DCLICK_GAP   25_000_000  max low samples between release and 2nd rise for double click; >=1
//   CNT_W        27          counter width; 2**CNT_W > max(LONG_CYCLES, DCLICK_GAP)
// PORTS
//   clock         in   1  system clock, all state on rising edge
//   reset         in   1  asynchronous, active-high reset
//   semnal        in   1  debounced button level (1 = pressed), synchronous to clock
//   press_pulse   out  1  1-cycle pulse on every rising edge of semnal
//   short_press   out  1  1-cycle pulse: single press shorter than LONG_CYCLES, no 2nd press in gap
//   long_press    out  1  1-cycle pulse: press held LONG_CYCLES samples
//   double_click  out  1  1-cycle pulse: 2nd rise within DCLICK_GAP low samples of release
//   held          out  1  semnal delayed one cycle
// BEHAVIOUR
//   Reset: state=IDLE, cnt=0, sig_q=1 (button held through reset is NOT a press),
//     all outputs 0. Reset asserted mid-operation aborts any pending event; nothing fires.
//   All outputs registered. held <= semnal. rise = semnal & ~sig_q; sig_q <= semnal.
//   press_pulse asserted the cycle after any rise sample, in every state.
//   FSM (one transition per edge; cnt cleared on every state change):
//     IDLE   : rise -> PRESS (cnt=1).
//     PRESS  : semnal=1: cnt++; when cnt reaches LONG_CYCLES -> LONG, long_press
//              asserted next cycle (i.e. cycle after the LONG_CYCLES-th high sample).
//              semnal=0 -> GAP (cnt=1).
//     LONG   : hold until semnal=0 -> IDLE. No short_press for a long press.
//     GAP    : rise (with cnt<=DCLICK_GAP) -> PRESS2, double_click next cycle.
//              else cnt++; when DCLICK_GAP-th low sample seen -> IDLE, short_press next cycle.
//     PRESS2 : wait semnal=0 -> IDLE. No long_press/short_press from second press.
//   Latency: short_press = DCLICK_GAP+1 cycles after first low sample;
//     long_press/double_click/press_pulse = 1 cycle after the qualifying sample.
//   Simultaneous: in GAP, rise on the same sample as gap expiry -> double_click wins,
//     short_press not issued. At most one of short/long/double per cycle.
//   Counter saturates at 2**CNT_W-1; never wraps.
//   Exactly one of short/long/double per press sequence, except a reset abort.
// TESTING  (LONG_CYCLES=8, DCLICK_GAP=4)
//   reset with semnal=1, release reset, hold 20 cycles -> no press_pulse, no events; held=1.
//   semnal high 3 cycles then low -> press_pulse once; short_press 1 cycle, 5 cycles after first low.
//   semnal high 10 cycles -> long_press 1 cycle after 8th high sample; no short_press on release.
//   high 3, low 2, high 3, low -> double_click 1 cycle after 2nd rise; 2 press_pulses; no short.
//   high 3, low exactly 4, high -> double_click (boundary), no short_press;
//     low 5 instead -> short_press then new sequence from 2nd press.
//   assert reset during GAP (after high 3, low 2) -> all outputs 0, no short_press after release.

Source files
------------

// File: rtl/button_event.sv
// Turns the debounced button level into one-cycle press/short/long/double-click pulses.
// Latency: every output is registered, one cycle after the qualifying sample; no backpressure (pulses are fire-and-forget).
module button_event #(
    parameter int LONG_CYCLES = 50_000_000,
    parameter int DCLICK_GAP  = 25_000_000,
    parameter int CNT_W       = 27
) (
    input  logic clock,
    input  logic reset,
    input  logic semnal,
    output logic press_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic held
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS,
        ST_LONG,
        ST_GAP,
        ST_PRESS2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DCLICK_GAP);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_q, sig_d;
    logic             press_pulse_q, press_pulse_d;
    logic             short_press_q, short_press_d;
    logic             long_press_q, long_press_d;
    logic             double_click_q, double_click_d;
    logic             held_q, held_d;

    logic             rise;
    logic [CNT_W-1:0] cnt_inc;

    assign rise    = semnal & ~sig_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        sig_d          = semnal;
        held_d         = semnal;
        press_pulse_d  = rise;
        short_press_d  = 1'b0;
        long_press_d   = 1'b0;
        double_click_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS: begin
                if (!semnal) begin
                    state_d = ST_GAP;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q >= LONG_LAST) begin
                    // this sample is the LONG_CYCLES-th high one, rise included
                    state_d      = ST_LONG;
                    cnt_d        = '0;
                    long_press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_LONG: begin
                if (!semnal) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_GAP: begin
                // a rise on the expiry sample still counts as a double click
                if (rise && cnt_q <= GAP_LAST) begin
                    state_d        = ST_PRESS2;
                    cnt_d          = '0;
                    double_click_d = 1'b1;
                end else if (cnt_q >= GAP_LAST) begin
                    state_d       = ST_IDLE;
                    cnt_d         = '0;
                    short_press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PRESS2: begin
                if (!semnal) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // sig_q resets high so a button held through reset is not seen as a rise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            sig_q          <= 1'b1;
            press_pulse_q  <= 1'b0;
            short_press_q  <= 1'b0;
            long_press_q   <= 1'b0;
            double_click_q <= 1'b0;
            held_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sig_q          <= sig_d;
            press_pulse_q  <= press_pulse_d;
            short_press_q  <= short_press_d;
            long_press_q   <= long_press_d;
            double_click_q <= double_click_d;
            held_q         <= held_d;
        end
    end

    assign press_pulse  = press_pulse_q;
    assign short_press  = short_press_q;
    assign long_press   = long_press_q;
    assign double_click = double_click_q;
    assign held         = held_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CYCLES=8, DCLICK_GAP=4.
module tb_button_event;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic semnal = 1'b1;
    logic press_pulse, short_press, long_press, double_click, held;

    int checks = 0;
    int failures = 0;
    int n_pp, n_sp, n_lp, n_dc;

    button_event #(
        .LONG_CYCLES(8),
        .DCLICK_GAP (4),
        .CNT_W      (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .semnal      (semnal),
        .press_pulse (press_pulse),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .held        (held)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_pp = 0; n_sp = 0; n_lp = 0; n_dc = 0;
    endtask

    // drive one sample, let the edge take it, then look at the registered outputs
    task automatic step(input logic v);
        semnal = v;
        @(posedge clock);
        #1;
        n_pp += int'(press_pulse);
        n_sp += int'(short_press);
        n_lp += int'(long_press);
        n_dc += int'(double_click);
    endtask

    task automatic steps(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    initial begin
        clr();
        // reset with the button held
        repeat (3) @(posedge clock);
        #1;
        chk("rst_outputs", int'({press_pulse, short_press, long_press, double_click, held}), 0);
        reset = 1'b0;
        steps(1'b1, 20);
        chk("held_through_reset_pp", n_pp, 0);
        chk("held_through_reset_events", n_sp + n_lp + n_dc, 0);
        chk("held_level", int'(held), 1);
        steps(1'b0, 6);
        chk("release_after_reset_events", n_pp + n_sp + n_lp + n_dc, 0);
        chk("held_low", int'(held), 0);

        // short press: high 3 then low
        clr();
        step(1'b1);
        chk("short_pp_first", int'(press_pulse), 1);
        steps(1'b1, 2);
        chk("short_pp_once", n_pp, 1);
        steps(1'b0, 4);
        chk("short_not_early", n_sp, 0);
        step(1'b0);
        chk("short_at_5th_low", int'(short_press), 1);
        step(1'b0);
        chk("short_one_cycle", int'(short_press), 0);
        steps(1'b0, 4);
        chk("short_total", n_sp, 1);
        chk("short_no_other", n_lp + n_dc, 0);

        // long press: high 10
        clr();
        steps(1'b1, 7);
        chk("long_not_early", n_lp, 0);
        step(1'b1);
        chk("long_after_8th", int'(long_press), 1);
        step(1'b1);
        chk("long_one_cycle", int'(long_press), 0);
        step(1'b1);
        steps(1'b0, 8);
        chk("long_total", n_lp, 1);
        chk("long_no_short", n_sp + n_dc, 0);

        // double click: high 3, low 2, high 3, low
        clr();
        steps(1'b1, 3);
        steps(1'b0, 2);
        step(1'b1);
        chk("dc_after_rise", int'(double_click), 1);
        chk("dc_second_pp", int'(press_pulse), 1);
        steps(1'b1, 2);
        chk("dc_one_cycle", int'(double_click), 0);
        steps(1'b0, 8);
        chk("dc_pp_count", n_pp, 2);
        chk("dc_total", n_dc, 1);
        chk("dc_no_short_long", n_sp + n_lp, 0);

        // boundary: low exactly 4 is still a double click
        clr();
        steps(1'b1, 3);
        steps(1'b0, 4);
        step(1'b1);
        chk("gap4_dc", int'(double_click), 1);
        chk("gap4_no_short_yet", n_sp, 0);
        steps(1'b1, 12);
        steps(1'b0, 8);
        chk("gap4_dc_total", n_dc, 1);
        chk("gap4_no_short_long", n_sp + n_lp, 0);

        // low 5: short press, then second press starts a fresh sequence
        clr();
        steps(1'b1, 3);
        steps(1'b0, 4);
        step(1'b0);
        chk("gap5_short", int'(short_press), 1);
        step(1'b1);
        chk("gap5_new_pp", int'(press_pulse), 1);
        chk("gap5_no_dc", int'(double_click), 0);
        steps(1'b1, 2);
        steps(1'b0, 5);
        chk("gap5_second_short", int'(short_press), 1);
        chk("gap5_short_total", n_sp, 2);
        chk("gap5_no_dc_long", n_dc + n_lp, 0);

        // reset in the gap aborts the pending short press
        clr();
        steps(1'b1, 3);
        steps(1'b0, 2);
        reset = 1'b1;
        #1;
        chk("abort_outputs", int'({press_pulse, short_press, long_press, double_click, held}), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        clr();
        steps(1'b0, 10);
        chk("abort_no_events", n_pp + n_sp + n_lp + n_dc, 0);
        step(1'b1);
        chk("abort_then_pp", int'(press_pulse), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
